// File: rtl/inst_cache_if.sv
// rtl/inst_cache_if.sv - fetch-side and refill-side signals of the instruction cache
interface inst_cache_if;
    logic        rdy;
    logic [31:0] pc_in;
    logic        flush;
    logic [31:0] flush_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;

    modport slave (
        input  rdy, pc_in, flush, flush_pc, mem_done, mem_data,
        output instr_valid, instr, mem_req, mem_addr
    );

    modport master (
        output rdy, pc_in, flush, flush_pc, mem_done, mem_data,
        input  instr_valid, instr, mem_req, mem_addr
    );
endinterface

// File: rtl/inst_cache.sv
// rtl/inst_cache.sv - direct-mapped instruction cache, 16-byte lines refilled word by word
module inst_cache #(
    parameter int INDEX_BITS = 6
) (
    input  logic         clk,
    input  logic         rst,
    inst_cache_if.slave  bus
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                state;
    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tags [LINES];
    logic [31:0]           data [LINES][4];
    logic [31:0]           line_buf [3];
    logic [1:0]            cnt;
    logic [31:2]           miss_addr;

    logic [31:2]           a;
    logic [TAG_BITS-1:0]   a_tag;
    logic [INDEX_BITS-1:0] a_idx;
    logic [1:0]            a_word;
    logic                  hit;
    logic                  do_lookup;
    logic [31:0]           fill_line [4];
    logic [INDEX_BITS-1:0] m_idx;
    logic                  unused_bits;

    assign a      = bus.flush ? bus.flush_pc[31:2] : bus.pc_in[31:2];
    assign a_tag  = a[31:INDEX_BITS+4];
    assign a_idx  = a[INDEX_BITS+3:4];
    assign a_word = a[3:2];
    assign hit    = valid[a_idx] && (tags[a_idx] == a_tag);
    assign m_idx  = miss_addr[INDEX_BITS+3:4];
    // A flush while refilling abandons (or follows) the refill with a fresh lookup of flush_pc.
    assign do_lookup   = (state == IDLE) || bus.flush;
    assign unused_bits = ^{bus.pc_in[1:0], bus.flush_pc[1:0]};

    // The fourth word is taken straight from the bus so the line is written the cycle it arrives.
    always_comb begin
        fill_line[0] = line_buf[0];
        fill_line[1] = line_buf[1];
        fill_line[2] = line_buf[2];
        fill_line[3] = bus.mem_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            valid           <= '0;
            cnt             <= 2'd0;
            miss_addr       <= '0;
            bus.instr_valid <= 1'b0;
            bus.instr       <= 32'd0;
            bus.mem_req     <= 1'b0;
            bus.mem_addr    <= 32'd0;
        end else if (bus.rdy) begin
            if (state == REFILL) begin
                bus.instr_valid <= 1'b0;
                if (bus.mem_done && cnt == 2'd3) begin
                    valid[m_idx] <= 1'b1;
                    tags[m_idx]  <= miss_addr[31:INDEX_BITS+4];
                    for (int w = 0; w < 4; w++) data[m_idx][w] <= fill_line[w];
                    cnt             <= 2'd0;
                    bus.mem_req     <= 1'b0;
                    state           <= IDLE;
                    bus.instr_valid <= 1'b1;
                    bus.instr       <= fill_line[miss_addr[3:2]];
                end else if (bus.flush) begin
                    cnt         <= 2'd0;
                    bus.mem_req <= 1'b0;
                    state       <= IDLE;
                end else if (bus.mem_done) begin
                    line_buf[cnt] <= bus.mem_data;
                    cnt           <= cnt + 2'd1;
                    bus.mem_addr  <= {miss_addr[31:4], cnt + 2'd1, 2'b00};
                end
            end
            // Lookup reads the array as it was before this edge, so a line
            // completing in this same cycle cannot hit yet.
            if (do_lookup) begin
                bus.instr_valid <= hit;
                if (hit) begin
                    bus.instr <= data[a_idx][a_word];
                end else begin
                    miss_addr    <= a;
                    cnt          <= 2'd0;
                    state        <= REFILL;
                    bus.mem_req  <= 1'b1;
                    bus.mem_addr <= {a[31:4], 4'b0000};
                end
            end
        end
    end
endmodule

// File: tb/tb_inst_cache.sv
// tb/tb_inst_cache.sv - directed self-checking bench for inst_cache
module tb_inst_cache;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    inst_cache_if bus();

    inst_cache #(.INDEX_BITS(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_hit(input string tag, input logic [31:0] word);
        check({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
        check({tag, "_instr"}, bus.instr, word);
        check({tag, "_req"}, 32'(bus.mem_req), 32'd0);
    endtask

    task automatic expect_miss(input string tag, input logic [31:0] addr);
        check({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
        check({tag, "_req"}, 32'(bus.mem_req), 32'd1);
        check({tag, "_addr"}, bus.mem_addr, addr);
    endtask

    task automatic give_word(input logic [31:0] addr);
        check("refill_req", 32'(bus.mem_req), 32'd1);
        check("refill_addr", bus.mem_addr, addr);
        bus.mem_done = 1'b1;
        bus.mem_data = {16'hC0DE, addr[15:0]};
        tick();
        bus.mem_done = 1'b0;
        bus.mem_data = 32'd0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        bus.rdy = 1'b1;
        bus.pc_in = 32'd0;
        bus.flush = 1'b0;
        bus.flush_pc = 32'd0;
        bus.mem_done = 1'b0;
        bus.mem_data = 32'd0;
        @(negedge clk);
        tick();
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instr", bus.instr, 32'd0);
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);

        // Cold miss on 0x8
        rst = 1'b0;
        bus.pc_in = 32'h8;
        tick();
        expect_miss("cold", 32'h0);
        give_word(32'h0);
        give_word(32'h4);
        give_word(32'h8);
        give_word(32'hC);
        expect_hit("cold_fill", 32'hC0DE_0008);

        // Back-to-back hits
        bus.pc_in = 32'h4;
        tick();
        expect_hit("hit4", 32'hC0DE_0004);
        bus.pc_in = 32'hC;
        tick();
        expect_hit("hitC", 32'hC0DE_000C);

        // Conflict eviction between 0x0 and 0x400
        bus.pc_in = 32'h0;
        tick();
        expect_hit("hit0", 32'hC0DE_0000);
        bus.pc_in = 32'h400;
        tick();
        expect_miss("miss400", 32'h400);
        give_word(32'h400);
        give_word(32'h404);
        give_word(32'h408);
        give_word(32'h40C);
        expect_hit("fill400", 32'hC0DE_0400);
        bus.pc_in = 32'h0;
        tick();
        expect_miss("evict0", 32'h0);
        give_word(32'h0);
        give_word(32'h4);
        give_word(32'h8);
        give_word(32'hC);
        expect_hit("refill0", 32'hC0DE_0000);

        // Flush abort mid-refill to a cached target
        bus.pc_in = 32'h100;
        tick();
        expect_miss("miss100", 32'h100);
        give_word(32'h100);
        give_word(32'h104);
        bus.flush = 1'b1;
        bus.flush_pc = 32'h4;
        tick();
        bus.flush = 1'b0;
        expect_hit("abort", 32'hC0DE_0004);
        tick();
        expect_miss("remiss100", 32'h100);
        bus.flush = 1'b1;
        bus.flush_pc = 32'hC;
        tick();
        bus.flush = 1'b0;
        expect_hit("abort2", 32'hC0DE_000C);

        // Flush coincident with the fourth word of 0x200
        bus.pc_in = 32'h200;
        tick();
        expect_miss("miss200", 32'h200);
        give_word(32'h200);
        give_word(32'h204);
        give_word(32'h208);
        check("last_addr", bus.mem_addr, 32'h20C);
        bus.mem_done = 1'b1;
        bus.mem_data = 32'hC0DE_020C;
        bus.flush = 1'b1;
        bus.flush_pc = 32'h300;
        tick();
        bus.mem_done = 1'b0;
        bus.flush = 1'b0;
        bus.pc_in = 32'h300;
        expect_miss("flush300", 32'h300);
        give_word(32'h300);
        give_word(32'h304);
        give_word(32'h308);
        give_word(32'h30C);
        expect_hit("fill300", 32'hC0DE_0300);
        bus.pc_in = 32'h204;
        tick();
        expect_hit("hit204", 32'hC0DE_0204);

        // rdy low while holding a hit
        bus.rdy = 1'b0;
        bus.pc_in = 32'h400;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_hit("stall_hit", 32'hC0DE_0204);
        end
        bus.rdy = 1'b1;
        bus.pc_in = 32'h100;
        tick();
        expect_miss("miss100b", 32'h100);
        give_word(32'h100);

        // rdy low mid-refill, with mem_done pulses that must be ignored
        bus.rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.mem_done = 1'b1;
            bus.mem_data = 32'hDEAD_BEEF;
            tick();
            expect_miss("stall_refill", 32'h104);
        end
        bus.mem_done = 1'b0;
        bus.rdy = 1'b1;
        give_word(32'h104);
        give_word(32'h108);
        give_word(32'h10C);
        expect_hit("fill100", 32'hC0DE_0100);
        bus.pc_in = 32'h108;
        tick();
        expect_hit("hit108", 32'hC0DE_0108);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
